// File: rtl/data_register_arb_pkg.sv
// Shared encodings for the Data_Register port arbiters.
// Requester IDs double as the round-robin last-grant value.
package data_register_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// A lone eligible requester always wins; on a tie the one not granted last wins.
module rr_pick2
    import data_register_arb_pkg::*;
(
    input  logic [1:0] eligible_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

    always_comb begin
        grant_valid_o = |eligible_i;
        grant_id_o    = REQ0;
        case (eligible_i)
            2'b01:   grant_id_o = REQ0;
            2'b10:   grant_id_o = REQ1;
            2'b11:   grant_id_o = ~last_grant_i;
            default: grant_id_o = REQ0;
        endcase
    end

endmodule

// File: rtl/data_register_write_arbiter.sv
// Round-robin arbiter sharing the Data_Register write port between two requesters.
// Grant visible one cycle after the request edge; every output comes straight from a flop.
module data_register_write_arbiter
    import data_register_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  arb_enable,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ack1,
    output logic                  enable_write,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy
);

    arb_state_e            state_q;
    logic                  last_grant_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  enable_write_q;
    logic [ADDR_WIDTH-1:0] write_addr_q;
    logic [DATA_WIDTH-1:0] write_data_q;

    logic [1:0] eligible;
    logic       grant_valid;
    logic       grant_id;

    // While granting, last_grant_q names the requester being acked; it sits out
    // this edge so a held request cannot be re-granted before it sees its ack.
    always_comb begin
        eligible = {req1, req0} & {2{arb_enable}};
        if (state_q == ST_GRANT) begin
            eligible[last_grant_q] = 1'b0;
        end
    end

    rr_pick2 u_pick (
        .eligible_i    (eligible),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= REQ1;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            enable_write_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
        end else if (grant_valid) begin
            state_q        <= ST_GRANT;
            last_grant_q   <= grant_id;
            ack0_q         <= (grant_id == REQ0);
            ack1_q         <= (grant_id == REQ1);
            enable_write_q <= 1'b1;
            write_addr_q   <= (grant_id == REQ1) ? addr1 : addr0;
            write_data_q   <= (grant_id == REQ1) ? data1 : data0;
        end else begin
            state_q        <= ST_IDLE;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            enable_write_q <= 1'b0;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign enable_write = enable_write_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign busy         = (state_q == ST_GRANT);

endmodule

// File: tb/tb_data_register_write_arbiter.sv
// Bench for data_register_write_arbiter: directed cases then randomized requesters,
// with a per-cycle reference model feeding an expected-write queue and a register-file model.
module tb_data_register_write_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       arb_enable;
    logic       req0, req1;
    logic [7:0] addr0, addr1, data0, data1;
    logic       ack0, ack1, enable_write, busy;
    logic [7:0] write_addr, write_data;

    always #5 clock = ~clock;

    data_register_write_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .arb_enable   (arb_enable),
        .req0         (req0),
        .addr0        (addr0),
        .data0        (data0),
        .ack0         (ack0),
        .req1         (req1),
        .addr1        (addr1),
        .data1        (data1),
        .ack1         (ack1),
        .enable_write (enable_write),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file the arbiter drives, plus the contents we expect it to hold.
    logic [7:0] rf     [256];
    logic [7:0] exp_rf [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            rf[i]     = 8'h00;
            exp_rf[i] = 8'h00;
        end
    end
    always @(posedge clock) if (enable_write === 1'b1) rf[write_addr] <= write_data;

    typedef struct {
        int         id;
        logic [7:0] addr;
        logic [7:0] data;
        int         stamp;
    } exp_t;
    exp_t sb[$];

    // Reference model: at each edge, decide who (if anyone) gets the write port.
    int   cyc    = 0;
    int   m_cur  = -1;
    int   m_last = 1;
    bit   e0, e1;
    int   winner;
    exp_t item;
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_cur  = -1;
            m_last = 1;
        end else begin
            e0 = req0 && arb_enable && (m_cur != 0);
            e1 = req1 && arb_enable && (m_cur != 1);
            winner = -1;
            if (e0 && e1)  winner = 1 - m_last;
            else if (e0)   winner = 0;
            else if (e1)   winner = 1;
            if (winner >= 0) begin
                item.id    = winner;
                item.addr  = (winner == 1) ? addr1 : addr0;
                item.data  = (winner == 1) ? data1 : data0;
                item.stamp = cyc;
                sb.push_back(item);
                exp_rf[item.addr] = item.data;
                m_last = winner;
            end
            m_cur = winner;
        end
    end

    // Monitor: compares what the DUT presents against the queue head each cycle.
    exp_t got;
    always @(negedge clock) begin
        if (cyc > 0) begin
            chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
            chk("en_eq_acks", {31'd0, enable_write}, {31'd0, ack0 | ack1});
            chk("busy_eq_en", {31'd0, busy}, {31'd0, enable_write});
            if (sb.size() > 0 && sb[0].stamp == cyc) begin
                got = sb.pop_front();
                chk("sb_enable", {31'd0, enable_write}, 32'd1);
                chk("sb_ack_id", {30'd0, ack1, ack0}, (got.id == 1) ? 32'd2 : 32'd1);
                chk("sb_addr", {24'd0, write_addr}, {24'd0, got.addr});
                chk("sb_data", {24'd0, write_data}, {24'd0, got.data});
            end else begin
                chk("sb_no_write", {31'd0, enable_write}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int prev, cur, nacks;

    initial begin
        reset = 1'b1; arb_enable = 1'b1;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
        repeat (3) tick();
        chk("rst_ack0", {31'd0, ack0}, 0);
        chk("rst_ack1", {31'd0, ack1}, 0);
        chk("rst_en", {31'd0, enable_write}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_addr", {24'd0, write_addr}, 0);
        chk("rst_data", {24'd0, write_data}, 0);
        reset = 1'b0;

        // Single write
        req0 = 1; addr0 = 8'h00; data0 = 8'h04;
        tick();
        chk("t1_ack0", {31'd0, ack0}, 1);
        chk("t1_en", {31'd0, enable_write}, 1);
        chk("t1_addr", {24'd0, write_addr}, 32'h00);
        chk("t1_data", {24'd0, write_data}, 32'h04);
        req0 = 0;
        tick();
        chk("t1_rf0", {24'd0, rf[0]}, 32'h04);

        // Simultaneous requests right after reset: requester 0 first
        do_reset();
        req0 = 1; addr0 = 8'h01; data0 = 8'h05;
        req1 = 1; addr1 = 8'h02; data1 = 8'h06;
        tick();
        chk("t2_first_ack0", {31'd0, ack0}, 1);
        req0 = 0;
        tick();
        chk("t2_second_ack1", {31'd0, ack1}, 1);
        req1 = 0;
        tick();
        chk("t2_rf1", {24'd0, rf[1]}, 32'h05);
        chk("t2_rf2", {24'd0, rf[2]}, 32'h06);

        // Both held: alternate every cycle
        req0 = 1; addr0 = 8'h10; data0 = 8'hA0;
        req1 = 1; addr1 = 8'h11; data1 = 8'hA1;
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_en_every_cycle", {31'd0, enable_write}, 1);
            cur = ack1 ? 1 : 0;
            if (prev >= 0) chk("t3_alternate", cur, 1 - prev);
            prev = cur;
        end
        req0 = 0; req1 = 0;
        tick(); tick();

        // Single held: one ack every other cycle
        req0 = 1; addr0 = 8'h20; data0 = 8'hB0;
        nacks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack0) nacks++;
        end
        chk("t3_single_rate", nacks, 4);
        req0 = 0;
        tick(); tick();

        // Arbitration disabled holds off grants
        arb_enable = 0; req1 = 1; addr1 = 8'h33; data1 = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_held_off", {31'd0, enable_write}, 0);
        end
        arb_enable = 1;
        tick();
        chk("t4_ack1_after_enable", {31'd0, ack1}, 1);
        req1 = 0;
        tick(); tick();

        // Reset during a grant: the write lands, then everything is cleared
        req0 = 1; addr0 = 8'h40; data0 = 8'hA5;
        tick();
        chk("t5_ack0", {31'd0, ack0}, 1);
        reset = 1; req0 = 0; req1 = 1; addr1 = 8'h41; data1 = 8'h5A;
        tick();
        chk("t5_rf_written", {24'd0, rf[8'h40]}, 32'hA5);
        chk("t5_en_cleared", {31'd0, enable_write}, 0);
        chk("t5_acks_cleared", {30'd0, ack1, ack0}, 0);
        chk("t5_addr_cleared", {24'd0, write_addr}, 0);
        tick();
        chk("t5_no_grant_in_reset", {31'd0, enable_write}, 0);
        reset = 0;
        tick();
        chk("t5_grant_after_reset", {31'd0, ack1}, 1);
        req1 = 0;
        tick(); tick();

        // Randomized requesters obeying the req/ack handshake
        for (int c = 0; c < 1500; c++) begin
            if (req0 && ack0) begin
                req0 = 1'($urandom_range(0, 1));
                if (req0) begin addr0 = 8'($urandom_range(0, 15)); data0 = 8'($urandom); end
            end else if (req0) begin
                if ($urandom_range(0, 15) == 0) req0 = 0;
            end else if ($urandom_range(0, 1) == 1) begin
                req0 = 1; addr0 = 8'($urandom_range(0, 15)); data0 = 8'($urandom);
            end
            if (req1 && ack1) begin
                req1 = 1'($urandom_range(0, 1));
                if (req1) begin addr1 = 8'($urandom_range(0, 15)); data1 = 8'($urandom); end
            end else if (req1) begin
                if ($urandom_range(0, 15) == 0) req1 = 0;
            end else if ($urandom_range(0, 1) == 1) begin
                req1 = 1; addr1 = 8'($urandom_range(0, 15)); data1 = 8'($urandom);
            end
            arb_enable = ($urandom_range(0, 7) != 0);
            tick();
        end
        req0 = 0; req1 = 0;
        repeat (4) tick();

        chk("sb_drained", sb.size(), 0);
        for (int a = 0; a < 256; a++) begin
            chk("rf_contents", {24'd0, rf[a]}, {24'd0, exp_rf[a]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
